// File: rtl/ipv4_rx_multi_if.sv
// rtl/ipv4_rx_multi_if.sv - MAC RX to transport RX stream bundle for the IPv4 receive filter
interface ipv4_rx_multi_if #(
    parameter int DATA_W = 16
);
    localparam int LEN_W = $clog2(DATA_W / 8 + 1);

    logic              valid_i;
    logic              start_i;
    logic              cancel_i;
    logic [DATA_W-1:0] data_i;
    logic [LEN_W-1:0]  len_i;

    logic              valid_o;
    logic              start_o;
    logic              last_o;
    logic              cancel_o;
    logic [DATA_W-1:0] data_o;
    logic [LEN_W-1:0]  len_o;
    logic              cs_err_o;
    logic              drop_o;

    modport master (
        output valid_i, start_i, cancel_i, data_i, len_i,
        input  valid_o, start_o, last_o, cancel_o, data_o, len_o, cs_err_o, drop_o
    );

    modport slave (
        input  valid_i, start_i, cancel_i, data_i, len_i,
        output valid_o, start_o, last_o, cancel_o, data_o, len_o, cs_err_o, drop_o
    );
endinterface

// File: rtl/ipv4_rx_multi.sv
// rtl/ipv4_rx_multi.sv - IPv4 RX filter: header check, dst table, checksum, payload trim
module ipv4_rx_multi #(
    parameter int                      DATA_W         = 16,
    parameter logic [7:0]              PROTOCOL       = 8'h11,
    parameter bit                      MATCH_DST_ADDR = 1'b1,
    parameter int                      DST_ADDR_N     = 2,
    parameter logic [32*DST_ADDR_N-1:0] DST_ADDR      = {DST_ADDR_N{32'hCEC87F80}}
) (
    input  logic          clk,
    input  logic          nreset,
    ipv4_rx_multi_if.slave bus
);
    localparam int LEN_W = $clog2(DATA_W / 8 + 1);
    localparam int NB    = DATA_W / 8;

    generate
        if (DATA_W != 16 && DATA_W != 32) begin : g_bad_width
            $error("ipv4_rx_multi: DATA_W must be 16 or 32");
        end
        if (DST_ADDR_N < 1 || DST_ADDR_N > 8) begin : g_bad_table
            $error("ipv4_rx_multi: DST_ADDR_N must be 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_DATA, ST_SKIP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  vihl_q, vihl_d;
    logic [15:0] tlen_q, tlen_d;
    logic [15:0] frag_q, frag_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] csum_q, csum_d;
    logic        sent_q, sent_d;

    logic        restart, hdr_word, hdr_end, pay, pass, csum_ok, dst_hit;
    logic [15:0] base_cnt, hdr_cnt_n, hlen, rem, len16, half;
    logic [16:0] sum17;
    logic [7:0]  vihl_n, proto_n;
    logic [15:0] tlen_n, frag_n, csum_n;
    logic [31:0] dst_n;
    logic [LEN_W-1:0] len_min;

    // Header field capture and running checksum for the word on the bus
    always_comb begin
        restart   = bus.valid_i & bus.start_i & ~bus.cancel_i;
        hdr_word  = restart | (bus.valid_i & ~bus.cancel_i & (state_q == ST_HEAD));
        base_cnt  = restart ? 16'd0 : cnt_q;
        vihl_n    = restart ? 8'd0  : vihl_q;
        tlen_n    = restart ? 16'd0 : tlen_q;
        frag_n    = restart ? 16'd0 : frag_q;
        proto_n   = restart ? 8'd0  : proto_q;
        dst_n     = restart ? 32'd0 : dst_q;
        csum_n    = restart ? 16'd0 : csum_q;
        half      = 16'd0;
        sum17     = 17'd0;
        for (int k = 0; k < NB; k++) begin
            case (base_cnt + 16'(k))
                16'd0:   vihl_n       = bus.data_i[8*k +: 8];
                16'd2:   tlen_n[15:8] = bus.data_i[8*k +: 8];
                16'd3:   tlen_n[7:0]  = bus.data_i[8*k +: 8];
                16'd6:   frag_n[15:8] = bus.data_i[8*k +: 8];
                16'd7:   frag_n[7:0]  = bus.data_i[8*k +: 8];
                16'd9:   proto_n      = bus.data_i[8*k +: 8];
                16'd16:  dst_n[31:24] = bus.data_i[8*k +: 8];
                16'd17:  dst_n[23:16] = bus.data_i[8*k +: 8];
                16'd18:  dst_n[15:8]  = bus.data_i[8*k +: 8];
                16'd19:  dst_n[7:0]   = bus.data_i[8*k +: 8];
                default: ;
            endcase
        end
        for (int j = 0; j < NB / 2; j++) begin
            half   = {bus.data_i[16*j +: 8], bus.data_i[16*j+8 +: 8]};
            sum17  = {1'b0, csum_n} + {1'b0, half};
            csum_n = sum17[15:0] + {15'd0, sum17[16]};
        end
        hdr_cnt_n = base_cnt + 16'(NB);
    end

    always_comb begin
        dst_hit = 1'b0;
        for (int i = 0; i < DST_ADDR_N; i++) begin
            if (dst_n == DST_ADDR[32*i +: 32]) dst_hit = 1'b1;
        end
        hlen    = {10'd0, vihl_n[3:0], 2'b00};
        csum_ok = (csum_n == 16'hFFFF);
        pass    = (vihl_n[7:4] == 4'd4) && (vihl_n[3:0] >= 4'd5)
                  && ((frag_n & 16'hBFFF) == 16'd0) && (proto_n == PROTOCOL)
                  && (tlen_n >= hlen) && (!MATCH_DST_ADDR || dst_hit) && csum_ok;
        hdr_end = bus.valid_i & ~bus.cancel_i & ~bus.start_i
                  & (state_q == ST_HEAD) & (hdr_cnt_n >= hlen);
        rem     = tlen_q - cnt_q;
        len16   = 16'(bus.len_i);
        len_min = (len16 < rem) ? bus.len_i : rem[LEN_W-1:0];
        pay     = bus.valid_i & ~bus.start_i & ~bus.cancel_i & (state_q == ST_DATA);
    end

    assign bus.valid_o  = pay;
    assign bus.start_o  = pay & ~sent_q;
    assign bus.last_o   = pay & (len16 >= rem);
    assign bus.len_o    = pay ? len_min : '0;
    assign bus.data_o   = pay ? bus.data_i : '0;
    assign bus.cancel_o = (state_q == ST_DATA) & sent_q
                          & (bus.cancel_i | (bus.valid_i & bus.start_i));
    assign bus.drop_o   = hdr_end & ~pass;
    assign bus.cs_err_o = hdr_end & ~csum_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vihl_d  = vihl_q;
        tlen_d  = tlen_q;
        frag_d  = frag_q;
        proto_d = proto_q;
        dst_d   = dst_q;
        csum_d  = csum_q;
        sent_d  = sent_q;
        if (hdr_word) begin
            cnt_d   = hdr_cnt_n;
            vihl_d  = vihl_n;
            tlen_d  = tlen_n;
            frag_d  = frag_n;
            proto_d = proto_n;
            dst_d   = dst_n;
            csum_d  = csum_n;
        end
        if (bus.cancel_i) begin
            state_d = ST_IDLE;
        end else if (restart) begin
            state_d = ST_HEAD;
            sent_d  = 1'b0;
        end else if (hdr_end) begin
            // A header that passes but carries no payload is skipped without a drop
            state_d = (pass && tlen_n != hlen) ? ST_DATA : ST_SKIP;
        end else if (pay) begin
            cnt_d  = cnt_q + len16;
            sent_d = 1'b1;
            if (len16 >= rem) state_d = ST_SKIP;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vihl_q  <= '0;
            tlen_q  <= '0;
            frag_q  <= '0;
            proto_q <= '0;
            dst_q   <= '0;
            csum_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vihl_q  <= vihl_d;
            tlen_q  <= tlen_d;
            frag_q  <= frag_d;
            proto_q <= proto_d;
            dst_q   <= dst_d;
            csum_q  <= csum_d;
            sent_q  <= sent_d;
        end
    end
endmodule

// File: tb/tb_ipv4_rx_multi.sv
// tb/tb_ipv4_rx_multi.sv - self-checking bench for ipv4_rx_multi at DATA_W 16 and 32
module tb_ipv4_rx_multi;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    localparam logic [63:0] TBL = {32'hC0A800C7, 32'hCEC87F80};

    ipv4_rx_multi_if #(.DATA_W(16)) a16 ();
    ipv4_rx_multi_if #(.DATA_W(32)) a32 ();

    ipv4_rx_multi #(.DATA_W(16), .DST_ADDR_N(2), .DST_ADDR(TBL)) dut16 (
        .clk(clk), .nreset(nreset), .bus(a16));
    ipv4_rx_multi #(.DATA_W(32), .DST_ADDR_N(2), .DST_ADDR(TBL)) dut32 (
        .clk(clk), .nreset(nreset), .bus(a32));

    typedef struct {
        bit          w32;
        bit          rst;
        bit          valid;
        bit          start;
        bit          cancel;
        logic [31:0] data;
        int          len;
    } beat_t;

    beat_t      bq[$];
    logic [7:0] fb[$];
    int n_checks = 0;
    int n_err    = 0;
    int obs_valid, obs_last, obs_full, obs_drop, obs_cs, obs_cancel;

    bit         m_frame, m_pay, m_sent;
    int         m_rem;
    logic [7:0] m_hdr[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ones_sum(input int n);
        int unsigned s = 0;
        for (int i = 0; i < n / 2; i++) s += {16'd0, m_hdr[2*i], m_hdr[2*i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    // Reference: frame-level view of the stream built from byte queues
    task automatic model_step(input beat_t b, output logic [31:0] e);
        int nb, hl, ln;
        bit v, s, l, c, ce, d, ok;
        logic [15:0] tl, cs;
        logic [31:0] dst;
        nb = b.w32 ? 4 : 2;
        {v, s, l, c, ce, d} = 6'b0;
        ln = 0;
        if (b.rst) begin
            m_frame = 0; m_pay = 0;
        end else if (b.cancel) begin
            c = m_pay && m_sent;
            m_frame = 0; m_pay = 0;
        end else if (b.valid && b.start) begin
            c = m_pay && m_sent;
            m_frame = 1; m_pay = 0; m_sent = 0;
            m_hdr.delete();
            for (int k = 0; k < nb; k++) m_hdr.push_back(b.data[8*k +: 8]);
        end else if (b.valid && m_frame && !m_pay) begin
            for (int k = 0; k < nb; k++) m_hdr.push_back(b.data[8*k +: 8]);
            hl = 4 * int'(m_hdr[0][3:0]);
            if (m_hdr.size() >= hl) begin
                tl  = {m_hdr[2], m_hdr[3]};
                dst = {m_hdr[16], m_hdr[17], m_hdr[18], m_hdr[19]};
                cs  = ones_sum(hl);
                ok  = (m_hdr[0][7:4] == 4) && (hl >= 20) && ((m_hdr[6] & 8'hBF) == 0)
                      && (m_hdr[7] == 0) && (m_hdr[9] == 8'h11) && (int'(tl) >= hl)
                      && (dst == TBL[31:0] || dst == TBL[63:32]) && (cs == 16'hFFFF);
                m_frame = 0;
                if (!ok) begin
                    d = 1; ce = (cs != 16'hFFFF);
                end else if (int'(tl) > hl) begin
                    m_frame = 1; m_pay = 1; m_sent = 0; m_rem = int'(tl) - hl;
                end
            end
        end else if (b.valid && m_pay) begin
            v  = 1;
            s  = !m_sent;
            ln = (b.len < m_rem) ? b.len : m_rem;
            l  = (b.len >= m_rem);
            m_rem -= b.len;
            m_sent = 1;
            if (l) begin m_frame = 0; m_pay = 0; end
        end
        e = {23'd0, v, s, l, c, ce, d, 3'(ln)};
    endtask

    task automatic idle16();
        a16.valid_i = 0; a16.start_i = 0; a16.cancel_i = 0; a16.data_i = '0; a16.len_i = '0;
    endtask
    task automatic idle32();
        a32.valid_i = 0; a32.start_i = 0; a32.cancel_i = 0; a32.data_i = '0; a32.len_i = '0;
    endtask

    task automatic run_beat(input string tag, input beat_t b);
        logic [31:0] e, got, gd, ed;
        @(negedge clk);
        nreset = !b.rst;
        idle16();
        idle32();
        if (!b.rst && !b.w32) begin
            a16.valid_i = b.valid; a16.start_i = b.start; a16.cancel_i = b.cancel;
            a16.data_i = b.data[15:0]; a16.len_i = 2'(b.len);
        end else if (!b.rst) begin
            a32.valid_i = b.valid; a32.start_i = b.start; a32.cancel_i = b.cancel;
            a32.data_i = b.data; a32.len_i = 3'(b.len);
        end
        #2;
        model_step(b, e);
        if (b.w32) begin
            got = {23'd0, a32.valid_o, a32.start_o, a32.last_o, a32.cancel_o,
                   a32.cs_err_o, a32.drop_o, a32.len_o};
            gd = a32.data_o; ed = b.data;
        end else begin
            got = {23'd0, a16.valid_o, a16.start_o, a16.last_o, a16.cancel_o,
                   a16.cs_err_o, a16.drop_o, 1'b0, a16.len_o};
            gd = {16'd0, a16.data_o}; ed = {16'd0, b.data[15:0]};
        end
        if (!b.rst) begin
            check_eq(tag, got, e);
            if (e[8]) check_eq({tag, "_data"}, gd, ed);
            if (got[8]) obs_valid++;
            if (got[6]) obs_last++;
            if (got[8] && got[2:0] == 3'((b.w32) ? 4 : 2)) obs_full++;
            if (got[5]) obs_cancel++;
            if (got[4]) obs_cs++;
            if (got[3]) obs_drop++;
        end
    endtask

    task automatic run_all(input string tag);
        obs_valid = 0; obs_last = 0; obs_full = 0; obs_drop = 0; obs_cs = 0; obs_cancel = 0;
        foreach (bq[i]) run_beat(tag, bq[i]);
        bq.delete();
    endtask

    task automatic add_rst();
        beat_t b;
        b.w32 = 0; b.rst = 1; b.valid = 0; b.start = 0; b.cancel = 0; b.data = 0; b.len = 0;
        bq.push_back(b);
    endtask

    task automatic add_frame(input bit w32, input bit gaps);
        beat_t b;
        int nb, i;
        bit first;
        nb = w32 ? 4 : 2;
        i = 0;
        first = 1;
        while (i < fb.size()) begin
            if (gaps && $urandom_range(3) == 0) begin
                b.w32 = w32; b.rst = 0; b.valid = 0; b.start = 1'($urandom_range(1));
                b.cancel = 0; b.data = $urandom; b.len = nb;
                bq.push_back(b);
            end
            b.w32 = w32; b.rst = 0; b.valid = 1; b.start = first; b.cancel = 0;
            b.data = 0; b.len = 0;
            for (int k = 0; k < nb && i < fb.size(); k++) begin
                b.data[8*k +: 8] = fb[i];
                i++;
                b.len++;
            end
            bq.push_back(b);
            first = 0;
        end
    endtask

    task automatic make_hdr(input int ihl, input logic [15:0] tl, input logic [15:0] flags,
                            input logic [7:0] proto, input logic [31:0] dst, input logic [3:0] ver);
        logic [15:0] cs;
        fb.delete();
        fb.push_back({ver, 4'(ihl)}); fb.push_back(8'h00);
        fb.push_back(tl[15:8]); fb.push_back(tl[7:0]);
        fb.push_back(8'h12); fb.push_back(8'h34);
        fb.push_back(flags[15:8]); fb.push_back(flags[7:0]);
        fb.push_back(8'h40); fb.push_back(proto);
        fb.push_back(8'h00); fb.push_back(8'h00);
        fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h00); fb.push_back(8'h01);
        for (int k = 3; k >= 0; k--) fb.push_back(dst[8*k +: 8]);
        for (int k = 0; k < (ihl - 5) * 4; k++) fb.push_back(8'($urandom));
        m_hdr = fb;
        cs = ~ones_sum(ihl * 4);
        fb[10] = cs[15:8];
        fb[11] = cs[7:0];
    endtask

    task automatic add_bytes(input int n);
        for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
    endtask

    task automatic truncate(input int idx);
        while (bq.size() > idx + 1) void'(bq.pop_back());
    endtask

    task automatic good_frame(input bit w32, input int plen);
        make_hdr(5, 16'(20 + plen), 16'h4000, 8'h11, 32'hC0A800C7, 4'd4);
        add_bytes(plen);
    endtask

    task automatic rand_frame(input bit w32);
        int ihl, plen, kind, base, r;
        logic [15:0] tl, flags;
        logic [7:0] proto;
        logic [31:0] dst;
        logic [3:0] ver;
        ihl = $urandom_range(5, 7);
        plen = $urandom_range(0, 40);
        tl = 16'(ihl * 4 + plen);
        flags = $urandom_range(1) ? 16'h4000 : 16'h0000;
        proto = 8'h11;
        dst = $urandom_range(1) ? 32'hC0A800C7 : 32'hCEC87F80;
        ver = 4'd4;
        kind = $urandom_range(0, 11);
        case (kind)
            1: flags = 16'h2000;
            2: proto = 8'h06;
            3: dst = 32'hC0A800C8;
            4: ver = 4'd6;
            5: tl = 16'(ihl * 4 - 4);
            6: flags = 16'h0001;
            default: ;
        endcase
        make_hdr(ihl, tl, flags, proto, dst, ver);
        if (kind == 7) fb[10] = fb[10] ^ 8'h01;
        add_bytes(plen + $urandom_range(0, 6));
        base = bq.size();
        add_frame(w32, 1);
        r = $urandom_range(0, 7);
        if (r == 0) begin
            r = $urandom_range(base, bq.size() - 1);
            bq[r].cancel = 1;
            truncate(r);
        end else if (r == 1) begin
            truncate($urandom_range(base, bq.size() - 1));
        end
    endtask

    initial begin
        logic [7:0] t1 [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                                8'h40, 8'h11, 8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01,
                                8'hC0, 8'hA8, 8'h00, 8'hC7};
        beat_t rb;
        int base;
        nreset = 0;
        idle16();
        idle32();
        m_frame = 0; m_pay = 0; m_sent = 0; m_rem = 0;

        // Accept at 16 bits: 95 payload bytes plus 4 padding
        add_rst();
        fb.delete();
        foreach (t1[i]) fb.push_back(t1[i]);
        add_bytes(99);
        add_frame(0, 0);
        run_all("accept16");
        check_eq("accept16_words", obs_valid, 48);
        check_eq("accept16_full", obs_full, 47);
        check_eq("accept16_last", obs_last, 1);

        add_rst();
        fb.delete();
        foreach (t1[i]) fb.push_back(t1[i]);
        fb[11] = 8'h62;
        add_bytes(99);
        add_frame(0, 0);
        run_all("bad_csum");
        check_eq("bad_csum_drop", obs_drop, 1);
        check_eq("bad_csum_cs", obs_cs, 1);
        check_eq("bad_csum_valid", obs_valid, 0);

        for (int r = 0; r < 3; r++) begin
            add_rst();
            make_hdr(5, 16'd40, (r == 0) ? 16'h2000 : 16'h4000, (r == 1) ? 8'h06 : 8'h11,
                     (r == 2) ? 32'hC0A800C8 : 32'hC0A800C7, 4'd4);
            add_bytes(20);
            add_frame(0, 0);
            run_all("reject");
            check_eq("reject_drop", obs_drop, 1);
            check_eq("reject_cs", obs_cs, 0);
            check_eq("reject_valid", obs_valid, 0);
        end

        // IHL=6 at 32 bits, 8-byte payload
        add_rst();
        make_hdr(6, 16'h0020, 16'h4000, 8'h11, 32'hC0A800C7, 4'd4);
        add_bytes(12);
        add_frame(1, 0);
        run_all("opt32");
        check_eq("opt32_words", obs_valid, 2);
        check_eq("opt32_full", obs_full, 2);
        check_eq("opt32_last", obs_last, 1);

        add_rst();
        good_frame(0, 20);
        base = bq.size();
        add_frame(0, 0);
        bq[base + 12].cancel = 1;
        truncate(base + 12);
        good_frame(0, 6);
        add_frame(0, 0);
        run_all("cancel_data");
        check_eq("cancel_data_cancel", obs_cancel, 1);
        check_eq("cancel_data_next", obs_last, 1);

        add_rst();
        good_frame(0, 20);
        base = bq.size();
        add_frame(0, 0);
        bq[base + 4].cancel = 1;
        truncate(base + 4);
        good_frame(0, 6);
        add_frame(0, 0);
        run_all("cancel_head");
        check_eq("cancel_head_cancel", obs_cancel, 0);
        check_eq("cancel_head_drop", obs_drop, 0);
        check_eq("cancel_head_next", obs_last, 1);

        add_rst();
        good_frame(0, 20);
        base = bq.size();
        add_frame(0, 0);
        truncate(base + 13);
        good_frame(0, 6);
        add_frame(0, 0);
        run_all("restart");
        check_eq("restart_cancel", obs_cancel, 1);
        check_eq("restart_next", obs_last, 1);

        add_rst();
        good_frame(1, 20);
        base = bq.size();
        add_frame(1, 0);
        rb = bq[0];
        bq.insert(base + 7, rb);
        good_frame(1, 6);
        add_frame(1, 0);
        run_all("reset_data");
        check_eq("reset_data_last", obs_last, 1);
        check_eq("reset_data_valid", obs_valid, 2 + 2);

        for (int s = 0; s < 30; s++) begin
            bit w;
            w = 1'($urandom_range(1));
            add_rst();
            for (int f = 0; f < 4; f++) rand_frame(w);
            run_all(w ? "rnd32" : "rnd16");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/ipv4_rx_multi.md
Name: ipv4_rx_multi

Overview:
- Parametrised IPv4 receive filter between the MAC RX stream and the transport RX stream. Successor to the 16-bit-only IPv4 RX filter.
- Supports DATA_W of 16 or 32 bits, a table of accepted destination addresses, and header checksum verification with one's-complement end-around carry.
- Frames are accepted or dropped as a whole once the header ends. Accepted frames get an explicit last-word marker, and bytes beyond Total Length are trimmed.

Parameters:
- DATA_W, 16, stream width in bits; legal values are 16 and 32 only (elaboration error otherwise).
- LEN_W, $clog2(DATA_W/8+1), width of the byte-count fields (derived, not overridable).
- PROTOCOL, 8'h11, accepted IP protocol (UDP).
- MATCH_DST_ADDR, 1, when 0 the destination address is not checked.
- DST_ADDR_N, 2, number of accepted destination addresses (1..8).
- DST_ADDR, {DST_ADDR_N{32'hCEC87F80}}, concatenated table; entry i is [32i+31:32i], written in network order (first byte in bits [31:24]).

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- valid_i  in  1  input word valid
- start_i  in  1  first header word of a frame, qualified by valid_i
- cancel_i  in  1  MAC aborts the current frame
- data_i  in  DATA_W  input word; byte k is in [8k+7:8k], byte 0 is first on the wire
- len_i  in  LEN_W  number of valid bytes; always the low bytes
- valid_o  out  1  payload word valid
- start_o  out  1  first payload word
- last_o  out  1  final payload word
- cancel_o  out  1  abort of a payload that has already started
- data_o  out  DATA_W  payload word (equal to data_i)
- len_o  out  LEN_W  valid payload bytes in this word
- cs_err_o  out  1  one-cycle pulse: header checksum mismatch
- drop_o  out  1  one-cycle pulse: frame rejected for any reason

Behaviour:
- Reset (nreset low at a clk edge): FSM goes to IDLE and all outputs are 0 from the next cycle.
- State only advances on cycles where valid_i=1; cancel_i and nreset act regardless of valid_i.
- FSM states are IDLE, HEAD, DATA and SKIP.
  - IDLE: on valid_i & start_i, consume the word as header bytes 0..DATA_W/8-1 and go to HEAD.
  - HEAD: when the header byte count reaches IHL*4, evaluate the filter. Pass goes to DATA; fail goes to SKIP and pulses drop_o in that cycle.
  - DATA: payload is forwarded. After the word with last_o, go to SKIP.
  - SKIP: ignore words until the next start_i.
- Filter pass requires all of:
  - version == 4
  - IHL >= 5
  - reserved flag == 0, MF == 0, fragment offset == 0 (DF is don't-care)
  - protocol == PROTOCOL
  - Total Length >= IHL*4
  - destination address equals any DST_ADDR entry (or MATCH_DST_ADDR == 0)
  - header checksum valid
- Header boundary: IHL*4 is a multiple of 4, so the header always ends on a word boundary for both legal widths. No realignment is needed.
- Checksum:
  - Accumulate 16-bit big-endian halves, each formed as {byte 2j, byte 2j+1}.
  - Include the checksum field itself.
  - For DATA_W=32, add both halves per cycle.
  - Fold each carry back in (17-bit add, end-around).
  - The header is valid iff the final sum is 16'hFFFF.
  - On failure, pulse cs_err_o together with drop_o.
- Payload:
  - rem = Total Length - bytes consumed so far, with a 16-bit counter.
  - valid_o = valid_i & DATA.
  - len_o = min(len_i, rem).
  - last_o = valid_o & (len_i >= rem).
  - start_o is high on the first payload word.
  - Trailing MAC padding and FCS are never forwarded.
- Zero payload (Total Length == IHL*4): go directly to SKIP. No start_o or valid_o is produced, and drop_o is not asserted.
- Output path is combinational from the inputs plus registered state: zero-cycle latency, no backpressure.
- cancel_i: next state is IDLE. cancel_o = cancel_i & DATA & (a payload word has already been sent). Otherwise the cancel is silent.
- start_i while in HEAD, DATA or SKIP: abandon the current frame and restart header parsing on that word.
  - If in DATA with payload already sent, assert cancel_o in the same cycle.
  - cancel_i has priority over start_i in the same cycle.
- A frame whose header is truncated by cancel_i produces neither drop_o nor cs_err_o.

Test Plan:
- Accept, DATA_W=16:
  - Stimulus: header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, with DST_ADDR entry 1 = C0A800C7, then 95 payload bytes and 4 padding bytes.
  - Required: start_o on the first payload word; 47 words with len_o=2; a final word with len_o=1 and last_o=1; no valid_o on the padding; cs_err_o=0.
- Same frame with the checksum field set to B862:
  - Required: cs_err_o=1 and drop_o=1 on the 10th header word; no valid_o for the rest of the frame.
- Filter rejects: separate runs with MF=1 (flags 0x2000), protocol 0x06, and destination C0A800C8.
  - Required: each run gives drop_o=1 at the end of the header and cs_err_o=0.
- Options and width, DATA_W=32:
  - Stimulus: IHL=6 with 4 option bytes, checksum recomputed, Total Length 0x0020 (8-byte payload).
  - Required: exactly 2 payload words with len_o=4; the second word has last_o=1.
- Cancel:
  - Stimulus: cancel_i on the 3rd payload word of an accepted frame.
  - Required: cancel_o=1 in that cycle; FSM is IDLE next; a following start_i frame is accepted normally.
  - Also: cancel_i during HEAD gives cancel_o=0 and drop_o=0.
- Restart and reset:
  - Stimulus: start_i mid-payload.
  - Required: cancel_o=1 and the new header is parsed.
  - Stimulus: nreset=0 for one cycle mid-DATA.
  - Required: all outputs 0 next cycle; FSM in IDLE.
